// File: rtl/toggle_rx.sv
// toggle_rx: receiver for a toggle-encoded (T-flip-flop) event line.
// Each level change on toggle_in is synchronized, detected as a one-cycle
// event_pulse, and accumulated in a saturating pending-event counter that
// the consumer drains with event_ack. Losing an event sets a sticky overflow.
// Optional feature: define TOGGLE_RX_TOTAL_COUNT_EN to add an 8-bit wrapping
// total_count output that counts every detected toggle.
module toggle_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             toggle_in,
    input  logic             event_ack,
    output logic             event_pulse,
    output logic             event_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
`ifdef TOGGLE_RX_TOTAL_COUNT_EN
    ,
    output logic [7:0]       total_count
`endif
);

    localparam logic [CNT_W-1:0] PENDING_FULL = '1;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_q;
    logic                   prev_q;
    logic                   detect;
    logic                   accept;
    logic [CNT_W-1:0]       pending_next;
    logic                   overflow_next;

    assign sync_q      = sync_chain[SYNC_STAGES-1];
    assign detect      = sync_q ^ prev_q;
    assign event_valid = (pending != '0);
    assign accept      = event_ack & event_valid;

    // Synchronizer chain; reset level 0 matches the transmitter TFF reset level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], toggle_in};
        end
    end

    // Edge-detect history and registered event strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= 1'b0;
            event_pulse <= 1'b0;
        end else begin
            prev_q      <= sync_q;
            event_pulse <= detect;
        end
    end

    // Saturating pending-counter update and overflow detection
    always_comb begin
        pending_next  = pending;
        overflow_next = overflow;
        if (detect && !accept) begin
            if (pending == PENDING_FULL) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending + 1'b1;
            end
        end else if (accept && !detect) begin
            pending_next = pending - 1'b1;
        end
    end

    // Pending counter and sticky overflow registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

`ifdef TOGGLE_RX_TOTAL_COUNT_EN
    // Free-running count of every detected toggle, wraps at 256
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_count <= '0;
        end else if (detect) begin
            total_count <= total_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_toggle_rx.sv
// Self-checking bench for toggle_rx: scoreboard of expected pulse cycles
// plus an event-count reference model of the pending counter.
module tb_toggle_rx;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int PMAX        = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset_n;
    logic             toggle_in;
    logic             event_ack;
    logic             event_pulse;
    logic             event_valid;
    logic [CNT_W-1:0] pending;
    logic             overflow;
`ifdef TOGGLE_RX_TOTAL_COUNT_EN
    logic [7:0]       total_count;
`endif

    toggle_rx #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .toggle_in   (toggle_in),
        .event_ack   (event_ack),
        .event_pulse (event_pulse),
        .event_valid (event_valid),
        .pending     (pending),
        .overflow    (overflow)
`ifdef TOGGLE_RX_TOTAL_COUNT_EN
        ,
        .total_count (total_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit in_reset = 1'b1;
    bit level = 1'b0;      // level the receiver has last been told about
    int exp_q[$];          // cycles at which a pulse must be seen (monitor)
    int det_q[$];          // edges at which a detect occurs (model)
    int mp = 0;            // model: pending events
    int ovf = 0;           // model: overflow flag
    int tot = 0;           // model: total detected toggles mod 256

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Any level change becomes one event, visible LAT edges later
    task automatic set_toggle(input bit v);
        if (v != level) begin
            exp_q.push_back(cyc + LAT);
            det_q.push_back(cyc + LAT);
        end
        level = v;
        toggle_in = v;
    endtask

    task automatic tick();
        bit det;
        bit acc;
        det = (det_q.size() > 0) && (det_q[0] == cyc + 1);
        if (det) void'(det_q.pop_front());
        acc = event_ack && (mp > 0);
        if (det && !acc) begin
            if (mp == PMAX) ovf = 1;
            else mp = mp + 1;
        end else if (acc && !det) begin
            mp = mp - 1;
        end
        if (det) tot = (tot + 1) % 256;
        @(posedge clock);
        #1;
        cyc++;
        check("pending", int'(pending), mp);
        check("overflow", int'(overflow), ovf);
        check("event_valid", int'(event_valid), (mp != 0) ? 1 : 0);
`ifdef TOGGLE_RX_TOTAL_COUNT_EN
        check("total_count", int'(total_count), tot);
`endif
    endtask

    // Asynchronous reset asserted mid-cycle, released just after an edge
    task automatic do_reset();
        #2;
        in_reset = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_pending", int'(pending), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_pulse", int'(event_pulse), 0);
        check("rst_valid", int'(event_valid), 0);
`ifdef TOGGLE_RX_TOTAL_COUNT_EN
        check("rst_total", int'(total_count), 0);
`endif
        exp_q.delete();
        det_q.delete();
        mp = 0;
        ovf = 0;
        tot = 0;
        level = 1'b0;
        event_ack = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        in_reset = 1'b0;
        set_toggle(toggle_in);
    endtask

    // Monitor: pulses must appear exactly where the scoreboard expects them
    initial begin
        forever begin
            @(negedge clock);
            if (!in_reset) begin
                if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                    void'(exp_q.pop_front());
                    check("event_pulse", int'(event_pulse), 1);
                end else begin
                    check("spurious_pulse", int'(event_pulse), 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        toggle_in = 1'b0;
        event_ack = 1'b0;
        reset_n   = 1'b0;
        #12;
        check("init_pending", int'(pending), 0);
        check("init_overflow", int'(overflow), 0);
        check("init_pulse", int'(event_pulse), 0);
        check("init_valid", int'(event_valid), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        in_reset = 1'b0;

        // Single toggle at cycle 10 -> pulse at cycle 13
        repeat (10) tick();
        set_toggle(1'b1);
        repeat (3) tick();
        check("first_event_pending", int'(pending), 1);
        check("first_event_valid", int'(event_valid), 1);
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;

        // Three spaced toggles, then four acks (last one ignored)
        for (int i = 0; i < 3; i++) begin
            set_toggle(~toggle_in);
            repeat (5) tick();
        end
        check("three_pending", int'(pending), 3);
        event_ack = 1'b1;
        repeat (4) tick();
        event_ack = 1'b0;
        check("drained_valid", int'(event_valid), 0);
        tick();

        // Saturation: 16 detects with no ack, then acks keep overflow set
        for (int i = 0; i < 16; i++) begin
            set_toggle(~toggle_in);
            repeat (2) tick();
        end
        repeat (4) tick();
        check("sat_pending", int'(pending), 15);
        check("sat_overflow", int'(overflow), 1);
        event_ack = 1'b1;
        repeat (3) tick();
        event_ack = 1'b0;
        check("sat_ack_overflow", int'(overflow), 1);

        // Fill to 15 from reset, then detect coinciding with ack
        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_toggle(~toggle_in);
            tick();
        end
        repeat (4) tick();
        set_toggle(~toggle_in);
        repeat (LAT - 1) tick();
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        check("full_ack_pending", int'(pending), 15);
        check("full_ack_overflow", int'(overflow), 0);

        // Drain to 5, then reset mid-cycle with toggle_in possibly high
        event_ack = 1'b1;
        repeat (10) tick();
        event_ack = 1'b0;
        check("five_pending", int'(pending), 5);
        do_reset();
        repeat (5) tick();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(2) == 0) set_toggle(~toggle_in);
            event_ack = 1'($urandom_range(1));
            tick();
        end
        event_ack = 1'b0;
        repeat (4) tick();

        // 260 back-to-back toggles from a clean reset
        toggle_in = 1'b0;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            set_toggle(~toggle_in);
            event_ack = 1'($urandom_range(1));
            tick();
        end
        event_ack = 1'b0;
        repeat (4) tick();
`ifdef TOGGLE_RX_TOTAL_COUNT_EN
        check("total_260", int'(total_count), 4);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
